// File: rtl/m68k_ram_port.sv
// 68000 bus-cycle front end for a 16-bit byte-lane work RAM, shared round-robin with a read-only aux port.
// Optional M68K_RAM_PORT_STATS_EN adds access/stall counters; dbg_state exposes the FSM state.
module m68k_ram_port #(
    parameter int WIDTHAD     = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_cs,
    input  logic               cpu_rw,
    input  logic               cpu_uds_n,
    input  logic               cpu_lds_n,
    input  logic [WIDTHAD-1:0] cpu_addr,
    input  logic [15:0]        cpu_din,
    output logic [15:0]        cpu_dout,
    output logic               cpu_dtack_n,
    input  logic               aux_req,
    input  logic [WIDTHAD-1:0] aux_addr,
    output logic               aux_ack,
    output logic [15:0]        aux_data,
    output logic [WIDTHAD-1:0] ram_addr,
    output logic [15:0]        ram_data,
    output logic               ram_we_uds_n,
    output logic               ram_we_lds_n,
    input  logic [15:0]        ram_q,
    output logic [2:0]         dbg_state
`ifdef M68K_RAM_PORT_STATS_EN
    ,
    output logic [15:0]        stat_cpu_cycles,
    output logic [15:0]        stat_aux_stall
`endif
);

    // Handshakes: the CPU holds cpu_cs for the whole bus cycle and is answered by cpu_dtack_n low
    // until it releases cpu_cs; the aux side holds aux_req until it sees the one-cycle aux_ack pulse.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_AUX    = 3'd4;

    localparam logic       HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]         r_state;
    logic [3:0]         r_wait_cnt;
    logic               r_last_grant;   // 1 = aux was granted last in a contested cycle
    logic [WIDTHAD-1:0] r_aux_addr;
    logic [15:0]        r_cpu_dout;
    logic               r_dtack_n;
    logic               r_aux_ack;
    logic [15:0]        r_aux_data;
    logic               w_cpu_wins;
    logic               w_in_access_wr;

    // CPU wins when it is alone or when the aux side took the previous contested grant.
    assign w_cpu_wins     = cpu_cs && (!aux_req || r_last_grant);
    assign w_in_access_wr = (r_state == S_ACCESS) && !cpu_rw;

    assign ram_addr     = (r_state == S_AUX) ? r_aux_addr : cpu_addr;
    assign ram_data     = cpu_din;
    assign ram_we_uds_n = !(w_in_access_wr && !cpu_uds_n);
    assign ram_we_lds_n = !(w_in_access_wr && !cpu_lds_n);
    assign cpu_dout     = r_cpu_dout;
    assign cpu_dtack_n  = r_dtack_n;
    assign aux_ack      = r_aux_ack;
    assign aux_data     = r_aux_data;
    assign dbg_state    = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 4'd0;
            r_last_grant <= 1'b1;
            r_aux_addr   <= '0;
            r_cpu_dout   <= 16'd0;
            r_dtack_n    <= 1'b1;
            r_aux_ack    <= 1'b0;
            r_aux_data   <= 16'd0;
        end else begin
            r_aux_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_wins) begin
                        r_wait_cnt <= WS_LOAD;
                        r_state    <= HAS_WAIT ? S_WAIT : S_ACCESS;
                        if (aux_req) begin
                            r_last_grant <= 1'b0;
                        end
                    end else if (aux_req) begin
                        r_aux_addr <= aux_addr;
                        r_state    <= S_AUX;
                        if (cpu_cs) begin
                            r_last_grant <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!cpu_cs) begin
                        r_state <= S_IDLE;
                    end else if (r_wait_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (cpu_rw) begin
                        r_cpu_dout <= ram_q;
                    end
                    // A cycle abandoned during the access still completes, but is never acknowledged.
                    if (cpu_cs) begin
                        r_state   <= S_DONE;
                        r_dtack_n <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!cpu_cs) begin
                        r_dtack_n <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_AUX: begin
                    r_aux_data <= ram_q;
                    r_aux_ack  <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef M68K_RAM_PORT_STATS_EN
    logic [15:0] r_stat_cpu;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_cpu   <= 16'd0;
            r_stat_stall <= 16'd0;
        end else begin
            if (r_state == S_ACCESS) begin
                r_stat_cpu <= r_stat_cpu + 16'd1;
            end
            if (aux_req && (r_state != S_AUX) && !r_aux_ack) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_cpu_cycles = r_stat_cpu;
    assign stat_aux_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_m68k_ram_port.sv
// Bench for m68k_ram_port: two instances (WAIT_STATES 0 and 3), each with its own behavioural RAM,
// checked every cycle against a timeline predicted from the bus-cycle latency rules.
module tb_m68k_ram_port;

    localparam int AW      = 10;
    localparam int NCYC    = 1024;
    localparam int ST_IDLE = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst [2];
    logic          cs [2];
    logic          rw [2];
    logic          uds_n [2];
    logic          lds_n [2];
    logic [AW-1:0] caddr [2];
    logic [15:0]   cdin [2];
    logic          aux_req;
    logic [AW-1:0] aux_addr;
    logic          aux_req_off;
    logic [AW-1:0] aux_addr_off;

    logic [15:0]   dout [2];
    logic          dtack [2];
    logic          ack [2];
    logic [15:0]   adata [2];
    logic [AW-1:0] raddr [2];
    logic [15:0]   rdata [2];
    logic          we_u [2];
    logic          we_l [2];
    logic [15:0]   rq [2];
    logic [2:0]    st [2];
`ifdef M68K_RAM_PORT_STATS_EN
    logic [15:0]   stat_cpu [2];
    logic [15:0]   stat_stall [2];
`endif

    m68k_ram_port #(.WIDTHAD(AW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .cpu_cs(cs[0]), .cpu_rw(rw[0]),
        .cpu_uds_n(uds_n[0]), .cpu_lds_n(lds_n[0]), .cpu_addr(caddr[0]), .cpu_din(cdin[0]),
        .cpu_dout(dout[0]), .cpu_dtack_n(dtack[0]), .aux_req(aux_req), .aux_addr(aux_addr),
        .aux_ack(ack[0]), .aux_data(adata[0]), .ram_addr(raddr[0]), .ram_data(rdata[0]),
        .ram_we_uds_n(we_u[0]), .ram_we_lds_n(we_l[0]), .ram_q(rq[0]), .dbg_state(st[0])
`ifdef M68K_RAM_PORT_STATS_EN
        , .stat_cpu_cycles(stat_cpu[0]), .stat_aux_stall(stat_stall[0])
`endif
    );

    m68k_ram_port #(.WIDTHAD(AW), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset(rst[1]), .cpu_cs(cs[1]), .cpu_rw(rw[1]),
        .cpu_uds_n(uds_n[1]), .cpu_lds_n(lds_n[1]), .cpu_addr(caddr[1]), .cpu_din(cdin[1]),
        .cpu_dout(dout[1]), .cpu_dtack_n(dtack[1]), .aux_req(aux_req_off), .aux_addr(aux_addr_off),
        .aux_ack(ack[1]), .aux_data(adata[1]), .ram_addr(raddr[1]), .ram_data(rdata[1]),
        .ram_we_uds_n(we_u[1]), .ram_we_lds_n(we_l[1]), .ram_q(rq[1]), .dbg_state(st[1])
`ifdef M68K_RAM_PORT_STATS_EN
        , .stat_cpu_cycles(stat_cpu[1]), .stat_aux_stall(stat_stall[1])
`endif
    );

    // ---------------- behavioural byte-lane RAMs (async read) ----------------
    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];
    logic        mem_init;

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 7) ^ 16'hA500;
    endfunction

    assign rq[0] = mem0[raddr[0]];
    assign rq[1] = mem1[raddr[1]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem0[i] <= init_word(i);
        end else begin
            if (!we_u[0]) mem0[raddr[0]][15:8] <= rdata[0][15:8];
            if (!we_l[0]) mem0[raddr[0]][7:0]  <= rdata[0][7:0];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= init_word(i);
        end else begin
            if (!we_u[1]) mem1[raddr[1]][15:8] <= rdata[1][15:8];
            if (!we_l[1]) mem1[raddr[1]][7:0]  <= rdata[1][7:0];
        end
    end

    // ---------------- model: expected per-cycle outputs and RAM contents ----------------
    logic        exp_we_u [2][NCYC];
    logic        exp_we_l [2][NCYC];
    logic        exp_dtack [2][NCYC];
    logic        exp_ack [2][NCYC];
    logic [15:0] exp_dout [2][NCYC];
    logic [15:0] exp_adata [2][NCYC];
    logic [15:0] shadow [2][1024];

    int checks   = 0;
    int failures = 0;
    int we_cyc [2];
    int dtack_first [2];
    bit checking = 1'b0;

    task automatic chk(input string name, input int d, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, d, cyc, got, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic fill_dout(input int d, input int from, input logic [15:0] v);
        for (int c = from; c < NCYC; c++) exp_dout[d][c] = v;
    endtask

    task automatic fill_adata(input int d, input int from, input logic [15:0] v);
        for (int c = from; c < NCYC; c++) exp_adata[d][c] = v;
    endtask

    task automatic expect_reset(input int d, input int from);
        for (int c = from; c < NCYC; c++) begin
            exp_we_u[d][c]  = 1'b1;
            exp_we_l[d][c]  = 1'b1;
            exp_dtack[d][c] = 1'b1;
            exp_ack[d][c]   = 1'b0;
            exp_dout[d][c]  = 16'd0;
            exp_adata[d][c] = 16'd0;
        end
    endtask

    task automatic merge_write(input int d, input logic [AW-1:0] a, input logic u, input logic l,
                               input logic [15:0] v);
        if (!u) shadow[d][a][15:8] = v[15:8];
        if (!l) shadow[d][a][7:0]  = v[7:0];
    endtask

    // Compare process: every cycle once checking is enabled.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!we_u[d] || !we_l[d]) we_cyc[d] = cyc;
            if (!dtack[d] && dtack_first[d] < 0) dtack_first[d] = cyc;
            if (checking && cyc < NCYC) begin
                chk("we_uds_n", d, 16'(we_u[d]), 16'(exp_we_u[d][cyc]));
                chk("we_lds_n", d, 16'(we_l[d]), 16'(exp_we_l[d][cyc]));
                chk("dtack_n", d, 16'(dtack[d]), 16'(exp_dtack[d][cyc]));
                chk("cpu_dout", d, dout[d], exp_dout[d][cyc]);
                chk("aux_ack", d, 16'(ack[d]), 16'(exp_ack[d][cyc]));
                chk("aux_data", d, adata[d], exp_adata[d][cyc]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU bus cycle: cs held for 'hold' cycles; 'delay' = cycles lost to arbitration.
    task automatic cpu_cycle(input int d, input logic rd, input logic u, input logic l,
                             input logic [AW-1:0] a, input logic [15:0] v,
                             input int hold, input int delay);
        int k, acc, m;
        k   = cyc;
        acc = k + 1 + ws_of(d) + delay;
        m   = k + hold;
        rw[d] = rd; uds_n[d] = u; lds_n[d] = l; caddr[d] = a; cdin[d] = v; cs[d] = 1'b1;
        if (m >= acc) begin
            if (!rd) begin
                exp_we_u[d][acc] = u;
                exp_we_l[d][acc] = l;
                merge_write(d, a, u, l, v);
            end else begin
                fill_dout(d, acc + 1, shadow[d][a]);
            end
            for (int c = acc + 1; c <= m; c++) exp_dtack[d][c] = 1'b0;
        end
        repeat (hold) tick();
        cs[d] = 1'b0;
        tick();
        tick();
    endtask

    // Aux read on dut0; ack expected 'ack_off' cycles after the request is raised.
    task automatic aux_request(input logic [AW-1:0] a, input int ack_off);
        int k;
        bit seen;
        k = cyc;
        aux_addr = a;
        aux_req  = 1'b1;
        exp_ack[0][k + ack_off] = 1'b1;
        fill_adata(0, k + ack_off, shadow[0][a]);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (ack[0]) seen = 1'b1;
        end
        aux_req = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL aux_ack_timeout dut0 cyc=%0d got=none exp=ack", cyc);
        end else begin
            chk("aux_ack_latency", 0, 16'(cyc - k), 16'(ack_off));
        end
    endtask

    // Full-word write with reset asserted after n cycles (while cs is still held).
    task automatic reset_in_state(input int d, input logic [AW-1:0] a, input logic [15:0] v, input int n);
        int k, acc;
        k   = cyc;
        acc = k + 1 + ws_of(d);
        rw[d] = 1'b0; uds_n[d] = 1'b0; lds_n[d] = 1'b0; caddr[d] = a; cdin[d] = v; cs[d] = 1'b1;
        if (acc <= k + n) begin
            exp_we_u[d][acc] = 1'b0;
            exp_we_l[d][acc] = 1'b0;
            merge_write(d, a, 1'b0, 1'b0, v);
            for (int c = acc + 1; c <= k + n; c++) exp_dtack[d][c] = 1'b0;
        end
        expect_reset(d, k + n + 1);
        repeat (n) tick();
        rst[d] = 1'b1;
        tick();
        rst[d] = 1'b0;
        cs[d]  = 1'b0;
        chk("state_after_reset", d, 16'(st[d]), 16'(ST_IDLE));
        chk("dtack_after_reset", d, 16'(dtack[d]), 16'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, err;
        mem_init = 1'b1;
        aux_req = 1'b0; aux_addr = '0; aux_req_off = 1'b0; aux_addr_off = '0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cs[d] = 1'b0; rw[d] = 1'b1; uds_n[d] = 1'b1; lds_n[d] = 1'b1;
            caddr[d] = '0; cdin[d] = '0; we_cyc[d] = -1; dtack_first[d] = -1;
            for (int i = 0; i < 1024; i++) shadow[d][i] = init_word(i);
            expect_reset(d, 0);
        end
        tick();
        tick();
        mem_init = 1'b0;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        checking = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_state", d, 16'(st[d]), 16'(ST_IDLE));
            chk("reset_dtack", d, 16'(dtack[d]), 16'd1);
            chk("reset_dout", d, dout[d], 16'd0);
        end

        // Full-word write, long cs; then read back.
        k = cyc; dtack_first[0] = -1;
        cpu_cycle(0, 1'b0, 1'b0, 1'b0, 10'h010, 16'hBEEF, 6, 0);
        chk("t1_strobe_cycle", 0, 16'(we_cyc[0] - k), 16'd1);
        chk("t1_dtack_cycle", 0, 16'(dtack_first[0] - k), 16'd2);
        cpu_cycle(0, 1'b1, 1'b0, 1'b0, 10'h010, 16'h0000, 3, 0);
        chk("t1_readback", 0, dout[0], 16'hBEEF);

        // Lower-byte write only.
        cpu_cycle(0, 1'b0, 1'b1, 1'b0, 10'h010, 16'h1234, 4, 0);
        cpu_cycle(0, 1'b1, 1'b0, 1'b0, 10'h010, 16'h0000, 3, 0);
        chk("t2_byte_readback", 0, dout[0], 16'hBE34);

        // Write with no strobes still gets DTACK.
        k = cyc; dtack_first[0] = -1;
        cpu_cycle(0, 1'b0, 1'b1, 1'b1, 10'h011, 16'hFFFF, 3, 0);
        chk("nostrobe_dtack_cycle", 0, 16'(dtack_first[0] - k), 16'd2);

        // cs dropped during ACCESS: write lands, no DTACK.
        dtack_first[0] = -1;
        cpu_cycle(0, 1'b0, 1'b0, 1'b0, 10'h012, 16'hC0DE, 1, 0);
        chk("early_drop_no_dtack", 0, 16'(dtack_first[0]), 16'hFFFF);
        cpu_cycle(0, 1'b1, 1'b0, 1'b0, 10'h012, 16'h0000, 3, 0);
        chk("early_drop_readback", 0, dout[0], 16'hC0DE);

        // Contention from reset: CPU first; aux gets IDLE after cs released (hold+1), AUX, then ack.
        fork
            cpu_cycle(0, 1'b1, 1'b0, 1'b0, 10'h020, 16'h0000, 4, 0);
            aux_request(10'h030, 7);
        join
        // Next contention: aux wins, CPU loses two cycles (AUX + ack IDLE).
        k = cyc; dtack_first[0] = -1;
        fork
            cpu_cycle(0, 1'b0, 1'b0, 1'b0, 10'h040, 16'h5A5A, 6, 2);
            aux_request(10'h010, 2);
        join
        chk("aux_first_dtack_cycle", 0, 16'(dtack_first[0] - k), 16'd4);
        chk("aux_first_data", 0, adata[0], 16'hBE34);

        // Reset during ACCESS and DONE (dut0), and during WAIT (dut1).
        reset_in_state(0, 10'h050, 16'h0F0F, 1);
        reset_in_state(0, 10'h051, 16'h7777, 2);
        reset_in_state(1, 10'h052, 16'h3333, 2);
        chk("wait_reset_mem_kept", 1, mem1[10'h052], 16'h0000 ^ init_word(16'h052));

        // Three wait states.
        k = cyc; dtack_first[1] = -1;
        cpu_cycle(1, 1'b1, 1'b0, 1'b0, 10'h005, 16'h0000, 7, 0);
        chk("ws3_dtack_cycle", 1, 16'(dtack_first[1] - k), 16'd5);
        chk("ws3_read", 1, dout[1], init_word(5));
        k = cyc;
        cpu_cycle(1, 1'b0, 1'b0, 1'b0, 10'h006, 16'hABCD, 7, 0);
        chk("ws3_strobe_cycle", 1, 16'(we_cyc[1] - k), 16'd4);
        we_cyc[1] = -1; dtack_first[1] = -1;
        cpu_cycle(1, 1'b0, 1'b0, 1'b0, 10'h007, 16'hFFFF, 2, 0);
        chk("ws3_abort_no_strobe", 1, 16'(we_cyc[1]), 16'hFFFF);
        chk("ws3_abort_no_dtack", 1, 16'(dtack_first[1]), 16'hFFFF);

`ifdef M68K_RAM_PORT_STATS_EN
        rst[0] = 1'b1;
        expect_reset(0, cyc + 1);
        tick();
        rst[0] = 1'b0;
        for (int i = 0; i < 4; i++) cpu_cycle(0, 1'b1, 1'b0, 1'b0, 10'(16'h060 + i), 16'h0000, 3, 0);
        fork
            cpu_cycle(0, 1'b1, 1'b0, 1'b0, 10'h070, 16'h0000, 1, 0);
            aux_request(10'h071, 4);
        join
        chk("stat_cpu_cycles", 0, stat_cpu[0], 16'd5);
        chk("stat_aux_stall", 0, stat_stall[0], 16'd3);
`endif

        tick();
        checking = 1'b0;
        err = 0;
        for (int i = 0; i < 1024; i++) if (mem0[i] !== shadow[0][i]) err++;
        chk("mem_sweep", 0, 16'(err), 16'd0);
        err = 0;
        for (int i = 0; i < 1024; i++) if (mem1[i] !== shadow[1][i]) err++;
        chk("mem_sweep", 1, 16'(err), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
